// File: rtl/img_pkg.sv
// rtl/img_pkg.sv - shared pixel types, colour modes and helpers for img_mem_reader_pipe
package img_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  typedef enum logic [1:0] {
    CM_RGB  = 2'd0,
    CM_GRAY = 2'd1,
    CM_NEG  = 2'd2,
    CM_TEST = 2'd3
  } color_mode_e;

  localparam int BAR_CNT = 8;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam rgb444_t [0:BAR_CNT-1] BAR_COLORS = {
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  // Keep the top 4 bits of each RGB565 field
  function automatic rgb444_t unpack565(input logic [15:0] d);
    logic unused_lsbs;
    unused_lsbs = ^{d[11], d[6:5], d[0]};
    unpack565 = '{r: d[15:12], g: d[10:7], b: d[4:1]};
  endfunction

  function automatic logic [3:0] to_gray(input rgb444_t p);
    logic [6:0] y;
    y = 7'({p.r, 1'b0}) + 7'(p.g) * 7'd5 + 7'(p.b);
    to_gray = 4'(y >> 3);
  endfunction

endpackage

// File: rtl/img_mem_reader_pipe_sync_delay_line.sv
// rtl/img_mem_reader_pipe_sync_delay_line.sv - fixed-depth shift register aligning control bits with read data
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= d;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/img_mem_reader_pipe.sv
// rtl/img_mem_reader_pipe.sv - frame RAM reader with 2^SCALE_SHIFT upscale and per-frame colour mode
// Define IMG_TEST_PATTERN_EN to make mode 3 emit eight vertical colour bars.
module img_mem_reader_pipe
  import img_pkg::*;
#(
  parameter int SRC_W       = 320,
  parameter int SRC_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = $clog2(SRC_W * SRC_H)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DE,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  input  logic [15:0]       imgData,
  output logic [3:0]        r_port,
  output logic [3:0]        g_port,
  output logic [3:0]        b_port,
  output logic              de_out,
  output logic              h_sync_out,
  output logic              v_sync_out
);

  localparam int WIN_W = SRC_W << SCALE_SHIFT;
  localparam int WIN_H = SRC_H << SCALE_SHIFT;
  localparam int LC_W  = (SCALE_SHIFT > 0) ? SCALE_SHIFT : 1;
  localparam logic [LC_W-1:0]   LC_MASK  = LC_W'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SRC_W);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(SRC_W * (SRC_H - 1));

  logic              in_win;
  logic              de_q, vs_q, de_fall, vs_rise, synced;
  logic [LC_W-1:0]   line_cnt, line_nxt;
  logic [ADDR_W-1:0] row_base;
  color_mode_e       mode_q;
  logic              win_d, de_d, hs_d, vs_d;
  rgb444_t           src, pix;
  logic [3:0]        gray;

  assign in_win  = DE && (int'(x_pixel) < WIN_W) && (int'(y_pixel) < WIN_H);
  assign de_fall = de_q && !DE;
  assign vs_rise = v_sync_in && !vs_q;
  // With SCALE_SHIFT=0 the mask is zero, so every line counts as a wrap
  assign line_nxt = (line_cnt + 1'b1) & LC_MASK;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr  <= '0;
      rd_en <= 1'b0;
    end else begin
      rd_en <= in_win;
      if (in_win) addr <= row_base + ADDR_W'(x_pixel >> SCALE_SHIFT);
    end
  end

  // Row accumulator stays parked at 0 after reset until the first frame start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q     <= 1'b0;
      vs_q     <= 1'b0;
      synced   <= 1'b0;
      line_cnt <= '0;
      row_base <= '0;
      mode_q   <= CM_RGB;
    end else begin
      de_q <= DE;
      vs_q <= v_sync_in;
      if (vs_rise) begin
        synced   <= 1'b1;
        line_cnt <= '0;
        row_base <= '0;
        mode_q   <= color_mode_e'(mode);
      end else if (de_fall && synced) begin
        line_cnt <= line_nxt;
        if (line_nxt == '0 && row_base < ROW_LAST) row_base <= row_base + ROW_STEP;
      end
    end
  end

`ifdef IMG_TEST_PATTERN_EN
  logic [2:0] bar_a, bar_d;

  assign bar_a = 3'(((int'(x_pixel) >> SCALE_SHIFT) * BAR_CNT) / SRC_W);

  sync_delay_line #(.WIDTH(7), .DEPTH(MEM_LATENCY + 1)) u_align (
    .clk   (clk),
    .reset (reset),
    .d     ({in_win, DE, h_sync_in, v_sync_in, bar_a}),
    .q     ({win_d, de_d, hs_d, vs_d, bar_d})
  );
`else
  sync_delay_line #(.WIDTH(4), .DEPTH(MEM_LATENCY + 1)) u_align (
    .clk   (clk),
    .reset (reset),
    .d     ({in_win, DE, h_sync_in, v_sync_in}),
    .q     ({win_d, de_d, hs_d, vs_d})
  );
`endif

  assign src  = unpack565(imgData);
  assign gray = to_gray(src);

  always_comb begin
    pix = src;
    case (mode_q)
      CM_GRAY: pix = '{r: gray, g: gray, b: gray};
      CM_NEG:  pix = '{r: 4'd15 - src.r, g: 4'd15 - src.g, b: 4'd15 - src.b};
`ifdef IMG_TEST_PATTERN_EN
      CM_TEST: pix = BAR_COLORS[bar_d];
`endif
      default: pix = src;
    endcase
    if (!(de_d && win_d)) pix = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_port     <= '0;
      g_port     <= '0;
      b_port     <= '0;
      de_out     <= 1'b0;
      h_sync_out <= 1'b0;
      v_sync_out <= 1'b0;
    end else begin
      r_port     <= pix.r;
      g_port     <= pix.g;
      b_port     <= pix.b;
      de_out     <= de_d;
      h_sync_out <= hs_d;
      v_sync_out <= vs_d;
    end
  end

endmodule

// File: tb/tb_img_mem_reader_pipe.sv
// tb/tb_img_mem_reader_pipe.sv - randomized bench for img_mem_reader_pipe against a per-pixel reference
module tb_img_mem_reader_pipe;

  localparam int SRC_W = 320;
  localparam int SRC_H = 240;
  localparam int SS    = 1;
  localparam int LAT   = 1;
  localparam int AW    = $clog2(SRC_W * SRC_H);
  localparam int OUT_DELAY = LAT + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          de, hs, vs;
  logic [9:0]    xp, yp;
  logic [1:0]    mode;
  logic [AW-1:0] addr;
  logic          rd_en;
  logic [15:0]   img_data = 16'h0;
  logic [3:0]    r_port, g_port, b_port;
  logic          de_out, hs_out, vs_out;

  always #5 clk = ~clk;

  img_mem_reader_pipe #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .SCALE_SHIFT(SS), .MEM_LATENCY(LAT), .ADDR_W(AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .DE         (de),
    .x_pixel    (xp),
    .y_pixel    (yp),
    .h_sync_in  (hs),
    .v_sync_in  (vs),
    .mode       (mode),
    .addr       (addr),
    .rd_en      (rd_en),
    .imgData    (img_data),
    .r_port     (r_port),
    .g_port     (g_port),
    .b_port     (b_port),
    .de_out     (de_out),
    .h_sync_out (hs_out),
    .v_sync_out (vs_out)
  );

  logic [15:0] ram [SRC_W*SRC_H];

  always @(posedge clk) begin : mem_model
    logic [AW-1:0] a;
    logic          r;
    a = addr;
    r = rd_en;
    #1;
    if (r) img_data = ram[a];
  end

  typedef struct {
    logic [14:0] e;
    int          x;
    int          y;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   model_mode = 0;
  logic vs_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] bar_color(input int i);
    case (i)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic logic [11:0] ref_pix(input int m, input logic [15:0] w, input int x);
    int r, g, b, y;
    r = int'(w[15:12]);
    g = int'(w[10:7]);
    b = int'(w[4:1]);
    if (m == 1) begin
      y = (2 * r + 5 * g + b) / 8;
      return {4'(y), 4'(y), 4'(y)};
    end
    if (m == 2) return {4'(15 - r), 4'(15 - g), 4'(15 - b)};
`ifdef IMG_TEST_PATTERN_EN
    if (m == 3) return bar_color(((x >> SS) * 8) / SRC_W);
`endif
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic step(input logic d, input int x, input int y, input logic h, input logic v);
    logic        win;
    int          a;
    logic [11:0] pix;
    exp_t        ent;
    de = d; xp = 10'(x); yp = 10'(y); hs = h; vs = v;
    if (v && !vs_prev) model_mode = int'(mode);
    vs_prev = v;
    win = d && (x < (SRC_W << SS)) && (y < (SRC_H << SS));
    a   = (y >> SS) * SRC_W + (x >> SS);
    pix = win ? ref_pix(model_mode, ram[a], x) : 12'h000;
    exp_q.push_back('{e: {d, h, v, pix}, x: x, y: y});
    @(posedge clk);
    #1;
    chk($sformatf("rd_en x=%0d y=%0d", x, y), 32'(rd_en), 32'(win));
    if (win) chk($sformatf("addr x=%0d y=%0d", x, y), 32'(addr), 32'(a));
    if (exp_q.size() == OUT_DELAY) begin
      ent = exp_q.pop_front();
      chk($sformatf("out m%0d x=%0d y=%0d", model_mode, ent.x, ent.y),
          32'({de_out, hs_out, vs_out, r_port, g_port, b_port}), 32'(ent.e));
    end
  endtask

  task automatic pipe_cleared();
    exp_t z;
    z = '{e: 15'h0, x: -1, y: -1};
    exp_q.delete();
    for (int i = 0; i < OUT_DELAY - 1; i++) exp_q.push_back(z);
    vs_prev    = 1'b0;
    model_mode = 0;
  endtask

  task automatic vsync_pulse();
    for (int i = 0; i < 3; i++) step(1'b0, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic drive_line(input int y, input bit full);
    if (full) begin
      for (int x = 0; x < 700; x++) step(1'b1, x, y, 1'b0, 1'b0);
    end else begin
      for (int n = 0; n < 6; n++) step(1'b1, int'($urandom_range(0, 719)), y, 1'b0, 1'b0);
      step(1'b1, 639, y, 1'b0, 1'b0);
      step(1'b1, 640, y, 1'b0, 1'b0);
    end
    step(1'b0, 0, y, 1'b1, 1'b0);
    step(1'b0, 0, y, 1'b1, 1'b0);
    step(1'b0, 0, y, 1'b0, 1'b0);
  endtask

  task automatic run_frame(input int m, input int m_mid, input int nlines);
    mode = 2'(m);
    vsync_pulse();
    for (int y = 0; y < nlines; y++) begin
      if (y == nlines / 2) mode = 2'(m_mid);
      drive_line(y, (y < 3) || (y == 479));
    end
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_rgb"}, 32'({r_port, g_port, b_port}), 32'h0);
    chk({tag, "_de_sync"}, 32'({de_out, hs_out, vs_out}), 32'h0);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'h0);
    chk({tag, "_addr"}, 32'(addr), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < SRC_W * SRC_H; i++) ram[i] = 16'($urandom);
    ram[0] = 16'hFFFF;
    ram[1] = 16'h8000;
    ram[2] = 16'h0000;

    reset = 1'b1; de = 1'b0; hs = 1'b0; vs = 1'b0; xp = '0; yp = '0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared("reset");
    reset = 1'b0;
    pipe_cleared();

    run_frame(0, 1, 480);
    run_frame(1, 2, 480);
    run_frame(2, 3, 480);
    run_frame(3, 0, 480);

    mode = 2'd1;
    vsync_pulse();
    for (int x = 0; x < 10; x++) step(1'b1, x, 0, 1'b0, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_cleared("midline_reset");
    de = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    pipe_cleared();

    mode = 2'd2;
    drive_line(0, 1'b0);
    drive_line(0, 1'b0);
    run_frame(2, 2, 4);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
